// File: rtl/ik_swift_pkg.sv
// Shared types and constants for the ik_swift core and its host bridge.
// Word width, joint/pose counts, word type and the bridge state encoding.
package ik_swift_pkg;

  localparam int IK_WIDTH      = 36;
  localparam int IK_NUM_JOINTS = 6;
  localparam int IK_POSE_WORDS = 6;

  typedef logic [IK_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    START,
    WAIT,
    UNLOAD
  } bridge_state_t;

endpackage

// File: rtl/ifc_ik_swift_host_bridge.sv
// Signal bundle around ik_swift_host_bridge.
// Modports: bridge (the DUT view), host (request/result link), core (ik_swift side).
interface ifc_ik_swift_host_bridge
  import ik_swift_pkg::*;
#(
  parameter int WIDTH      = IK_WIDTH,
  parameter int NUM_JOINTS = IK_NUM_JOINTS,
  parameter int POSE_WORDS = IK_POSE_WORDS
) (
  input logic clk
);

  logic                         reset;
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  logic                         in_last;
  logic                         core_start;
  logic [NUM_JOINTS*WIDTH-1:0]  core_theta;
  logic [POSE_WORDS*WIDTH-1:0]  core_target;
  logic                         core_done;
  logic [NUM_JOINTS*WIDTH-1:0]  core_result;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_data;
  logic                         out_last;
  logic                         err_frame;
  logic                         err_timeout;

  modport bridge (
    input  clk, reset, in_valid, in_data, in_last,
    input  core_done, core_result, out_ready,
    output in_ready, core_start, core_theta, core_target,
    output out_valid, out_data, out_last, err_frame, err_timeout
  );

  modport host (
    input  clk, in_ready, out_valid, out_data, out_last,
    input  err_frame, err_timeout,
    output reset, in_valid, in_data, in_last, out_ready
  );

  modport core (
    input  clk, core_start, core_theta, core_target,
    output core_done, core_result
  );

endinterface

// File: rtl/ik_swift_result_ser.sv
// Parallel-to-serial result register: loads all joints at once, then
// emits them word 0 first on a valid/ready stream with last on the final word.
module ik_swift_result_ser #(
  parameter int WIDTH      = 36,
  parameter int NUM_JOINTS = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NUM_JOINTS*WIDTH-1:0] load_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last
);

  localparam int IW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_JOINTS - 1);

  logic [NUM_JOINTS*WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        valid_q, valid_d;
  logic                        at_last;

  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      res_d   = load_data;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      if (at_last) valid_d = 1'b0;
      else         idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = res_q[int'(idx_q)*WIDTH +: WIDTH];
  assign out_last  = valid_q && at_last;

endmodule

// File: rtl/ik_swift_host_bridge.sv
// Host front end for ik_swift: loads a theta+pose frame word by word,
// starts the core, waits (with timeout) and streams the solved angles back.
module ik_swift_host_bridge
  import ik_swift_pkg::*;
#(
  parameter int WIDTH      = IK_WIDTH,
  parameter int NUM_JOINTS = IK_NUM_JOINTS,
  parameter int POSE_WORDS = IK_POSE_WORDS,
  parameter int TIMEOUT    = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_last,
  output logic                        core_start,
  output logic [NUM_JOINTS*WIDTH-1:0] core_theta,
  output logic [POSE_WORDS*WIDTH-1:0] core_target,
  input  logic                        core_done,
  input  logic [NUM_JOINTS*WIDTH-1:0] core_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
  output logic                        err_frame,
  output logic                        err_timeout
);

  localparam int FRAME = NUM_JOINTS + POSE_WORDS;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(FRAME - 1);
  localparam logic [CW-1:0] NJ_C      = CW'(NUM_JOINTS);
  localparam logic [TW-1:0] TO_LAST   =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  bridge_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [NUM_JOINTS*WIDTH-1:0] theta_q, theta_d;
  logic [POSE_WORDS*WIDTH-1:0] target_q, target_d;
  logic err_frame_q, err_frame_d;
  logic err_timeout_q, err_timeout_d;

  logic          accept;
  logic          ser_load;
  logic [CW-1:0] idx;
  int            slot;

  assign in_ready = !reset &&
    (state_q == IDLE || state_q == LOAD || state_q == DRAIN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    theta_d       = theta_q;
    target_d      = target_q;
    err_frame_d   = err_frame_q;
    err_timeout_d = err_timeout_q;
    ser_load      = 1'b0;
    // The first word of a frame is always slot 0, whatever cnt holds.
    idx           = (state_q == IDLE) ? '0 : cnt_q;
    slot          = int'(idx);
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (idx < NJ_C)
            theta_d[slot*WIDTH +: WIDTH] = in_data;
          else
            target_d[(slot-NUM_JOINTS)*WIDTH +: WIDTH] = in_data;
          if (in_last) begin
            cnt_d = '0;
            if (idx == LAST_WORD) begin
              state_d = START;
            end else begin
              err_frame_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (idx == LAST_WORD) begin
            // Frame is full but the host keeps sending: swallow the rest.
            cnt_d       = '0;
            err_frame_d = 1'b1;
            state_d     = DRAIN;
          end else begin
            cnt_d   = idx + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) state_d = IDLE;
      end
      START: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          ser_load = 1'b1;
          state_d  = UNLOAD;
        end else if ((TIMEOUT != 0) && (tmr_q == TO_LAST)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (out_valid && out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      theta_q       <= '0;
      target_q      <= '0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      theta_q       <= theta_d;
      target_q      <= target_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign core_start  = (state_q == START);
  assign core_theta  = theta_q;
  assign core_target = target_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;

  ik_swift_result_ser #(
    .WIDTH      (WIDTH),
    .NUM_JOINTS (NUM_JOINTS)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (core_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule
